// File: rtl/mux4_1_if.sv
// Data/select bundle for the mux4_1 selector cell.
// The bench (master) drives w0..w3 and sel; the cell (slave) drives out and out_q.
interface mux4_1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] w0;
  logic [WIDTH-1:0] w1;
  logic [WIDTH-1:0] w2;
  logic [WIDTH-1:0] w3;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;

  modport master (
    output w0, w1, w2, w3, sel,
    input  out, out_q
  );

  modport slave (
    input  w0, w1, w2, w3, sel,
    output out, out_q
  );
endinterface

// File: rtl/mux4_1.sv
// Four-input selector built from two 2:1 stages, with an optional registered copy.
// out is purely combinational; out_q is out delayed one clk and cleared by reset.
module mux4_1 #(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           reset,
  mux4_1_if.slave        bus
);

  logic [WIDTH-1:0] stage_lo;
  logic [WIDTH-1:0] stage_hi;
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] out_q_reg;

  // Case with an X default so an unknown select bit yields X instead of w0.
  always_comb begin
    stage_lo = 'x;
    stage_hi = 'x;
    case (bus.sel[0])
      1'b0: begin
        stage_lo = bus.w0;
        stage_hi = bus.w2;
      end
      1'b1: begin
        stage_lo = bus.w1;
        stage_hi = bus.w3;
      end
      default: begin
        stage_lo = 'x;
        stage_hi = 'x;
      end
    endcase
  end

  always_comb begin
    out_next = 'x;
    case (bus.sel[1])
      1'b0:    out_next = stage_lo;
      1'b1:    out_next = stage_hi;
      default: out_next = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q_reg <= '0;
    end else begin
      out_q_reg <= out_next;
    end
  end

  assign bus.out   = out_next;
  assign bus.out_q = out_q_reg;

endmodule

// File: tb/tb_mux4_1.sv
// Directed self-checking bench for mux4_1: a 1-bit cell with the register path
// and a 64-bit cell for the wide decode.
module tb_mux4_1;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mux4_1_if #(.WIDTH(1))  b1 ();
  mux4_1_if #(.WIDTH(64)) b64 ();

  mux4_1 #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  mux4_1 #(.WIDTH(64)) dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (b64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    // Time 1: reset high, no clk edge has happened yet.
    #1;
    checks++;
    if (b1.out_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: out_q=%b expected 0", b1.out_q);
    end
    $display("reset_initial: out_q=%b", b1.out_q);
  endtask

  task automatic test_static_decode();
    logic exp_vals [4];
    exp_vals[0] = 1'b0; exp_vals[1] = 1'b1; exp_vals[2] = 1'b0; exp_vals[3] = 1'b1;
    b1.w0 = 1'b0; b1.w1 = 1'b1; b1.w2 = 1'b0; b1.w3 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      b1.sel = 2'(s);
      #10;
      checks++;
      if (b1.out !== exp_vals[s]) begin
        errors++;
        $display("FAIL static_decode sel=%0d: out=%b expected %b", s, b1.out, exp_vals[s]);
      end
      $display("static_decode sel=%0d out=%b", s, b1.out);
    end
  endtask

  task automatic test_exhaustive();
    logic [5:0] v;
    logic       w [4];
    logic       exp_out;
    int         bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      w[0] = v[5]; w[1] = v[4]; w[2] = v[3]; w[3] = v[2];
      b1.w0 = w[0]; b1.w1 = w[1]; b1.w2 = w[2]; b1.w3 = w[3];
      b1.sel = v[1:0];
      #1;
      exp_out = w[v[1:0]];
      checks++;
      if (b1.out !== exp_out) begin
        errors++;
        bad++;
        $display("FAIL exhaustive w=%b%b%b%b sel=%0d: out=%b expected %b",
                 w[0], w[1], w[2], w[3], v[1:0], b1.out, exp_out);
      end
    end
    $display("exhaustive: 64 vectors, %0d wrong", bad);
  endtask

  task automatic test_wide();
    logic [63:0] exp_out;
    b64.w0 = 64'd0; b64.w1 = 64'd1; b64.w2 = 64'd2; b64.w3 = 64'd3;
    for (int s = 0; s < 5; s++) begin
      b64.sel = (s == 4) ? 2'd0 : 2'(s);
      exp_out = (s == 4) ? 64'd0 : 64'(s);
      #10;
      checks++;
      if (b64.out !== exp_out) begin
        errors++;
        $display("FAIL wide sel=%0d: out=%0d expected %0d", b64.sel, b64.out, exp_out);
      end
      $display("wide sel=%0d out=%0d", b64.sel, b64.out);
    end
  endtask

  task automatic test_register();
    // Load a 1 first so the asynchronous clear is observable.
    @(negedge clk);
    reset = 1'b0;
    b1.sel = 2'd3; b1.w3 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b1.out_q !== 1'b1) begin
      errors++;
      $display("FAIL reg_preload: out_q=%b expected 1", b1.out_q);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (b1.out_q !== 1'b0) begin
      errors++;
      $display("FAIL reg_async_clear: out_q=%b expected 0", b1.out_q);
    end
    $display("reg_async_clear: out_q=%b", b1.out_q);
    @(posedge clk); #1;
    checks++;
    if (b1.out_q !== 1'b0) begin
      errors++;
      $display("FAIL reg_hold_in_reset: out_q=%b expected 0", b1.out_q);
    end
    @(negedge clk);
    reset = 1'b0;
    b1.sel = 2'd2; b1.w2 = 1'b1; b1.w0 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b1.out_q !== 1'b1) begin
      errors++;
      $display("FAIL reg_first_capture: out_q=%b expected 1", b1.out_q);
    end
    $display("reg_first_capture: out_q=%b", b1.out_q);
    #1 b1.sel = 2'd0;
    #1;
    checks++;
    if (b1.out !== 1'b0 || b1.out_q !== 1'b1) begin
      errors++;
      $display("FAIL reg_sel_change: out=%b out_q=%b expected out=0 out_q=1", b1.out, b1.out_q);
    end
    $display("reg_sel_change: out=%b out_q=%b", b1.out, b1.out_q);
    @(posedge clk); #1;
    checks++;
    if (b1.out_q !== 1'b0) begin
      errors++;
      $display("FAIL reg_next_edge: out_q=%b expected 0", b1.out_q);
    end
    $display("reg_next_edge: out_q=%b", b1.out_q);
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    b1.sel = 2'd1; b1.w1 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b1.out_q !== 1'b1) begin
      errors++;
      $display("FAIL mid_preload: out_q=%b expected 1", b1.out_q);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (b1.out_q !== 1'b0 || b1.out !== 1'b1) begin
      errors++;
      $display("FAIL mid_pulse: out=%b out_q=%b expected out=1 out_q=0", b1.out, b1.out_q);
    end
    $display("mid_pulse: out=%b out_q=%b", b1.out, b1.out_q);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (b1.out_q !== 1'b0 || b1.out !== 1'b1) begin
      errors++;
      $display("FAIL mid_release: out=%b out_q=%b expected out=1 out_q=0", b1.out, b1.out_q);
    end
    @(posedge clk); #1;
    checks++;
    if (b1.out_q !== 1'b1) begin
      errors++;
      $display("FAIL mid_recapture: out_q=%b expected 1", b1.out_q);
    end
    $display("mid_recapture: out_q=%b", b1.out_q);
  endtask

  task automatic test_x_prop();
    logic [1:0] xsel;
    xsel = 2'bx0;
    @(negedge clk);
    b1.w0 = 1'b0; b1.w1 = 1'b1; b1.w2 = 1'b1; b1.w3 = 1'b0;
    b1.sel = xsel;
    #1;
    if ($isunknown(b1.sel)) begin
      checks++;
      if (!$isunknown(b1.out)) begin
        errors++;
        $display("FAIL x_out: out=%b expected x", b1.out);
      end
      @(posedge clk); #1;
      checks++;
      if (!$isunknown(b1.out_q)) begin
        errors++;
        $display("FAIL x_out_q: out_q=%b expected x", b1.out_q);
      end
      $display("x_prop: out=%b out_q=%b", b1.out, b1.out_q);
    end else begin
      $display("x_prop: two-state simulator, unknown select not representable");
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    b1.w0 = '0; b1.w1 = '0; b1.w2 = '0; b1.w3 = '0; b1.sel = 2'd0;
    b64.w0 = '0; b64.w1 = '0; b64.w2 = '0; b64.w3 = '0; b64.sel = 2'd0;
    test_reset();
    test_static_decode();
    test_exhaustive();
    test_wide();
    test_register();
    test_reset_midstream();
    test_x_prop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
